// File: rtl/netlist_bist_pkg.sv
// netlist_bist_pkg: shared types and helpers for the netlist BIST sequencer.
// Holds the sequencer FSM state encoding, the default MISR polynomial/seed,
// and the MISR next-state function used by the signature register.
package netlist_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_t;

    localparam logic [15:0] DEF_POLY   = 16'h1021;
    localparam logic [15:0] DEF_SEED   = 16'hFFFF;
    localparam int          MISR_MAX_W = 32;

    // One MISR step on a register of width w (w <= MISR_MAX_W), right-aligned
    // in a MISR_MAX_W container: shift left, fold the old MSB back through the
    // polynomial, and xor the response bit into bit 0.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] poly,
        input logic                  n_bit,
        input int                    w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] msb_mask;
        logic                  fb;
        mask     = '1;
        mask     = mask >> (MISR_MAX_W - w);
        msb_mask = mask ^ (mask >> 1);
        fb       = |(sig & msb_mask);
        return ((sig << 1) ^ ({MISR_MAX_W{fb}} & poly) ^
                {{(MISR_MAX_W-1){1'b0}}, n_bit}) & mask;
    endfunction

endpackage

// File: rtl/netlist_bist_misr.sv
// netlist_bist_misr: signature register for the netlist BIST sequencer.
// load reseeds the register, shift compacts one n_in response bit. sig_nxt
// exposes the value the next shift would produce so the controller can grade
// the final signature in the same cycle it is captured.
import netlist_bist_pkg::*;

module netlist_bist_misr #(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             n_in,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_nxt
);

    assign sig_nxt = SIG_W'(misr_step(MISR_MAX_W'(sig), MISR_MAX_W'(POLY), n_in, SIG_W));

    // Signature register: reseed on load, compact on shift, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (load) begin
            sig <= SEED;
        end else if (shift) begin
            sig <= sig_nxt;
        end
    end

endmodule

// File: rtl/netlist_bist_ctrl.sv
// netlist_bist_ctrl: exhaustive-sweep BIST sequencer for small combinational
// netlists. Drives every {L,s} combination for SETTLE cycles, samples n_in in
// a following SAMPLE cycle, compacts the responses into a MISR and grades the
// final signature against expected_sig.
// Optional feature macro: NETBIST_ONES_CNT_EN adds the ones_cnt output that
// counts sampled n_in=1 responses over a sweep.
import netlist_bist_pkg::*;

module netlist_bist_ctrl #(
    parameter int               S_W    = 4,
    parameter int               L_W    = 3,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
    parameter int               SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SIG_W-1:0] expected_sig,
    input  logic             n_in,
    output logic [S_W-1:0]   s_out,
    output logic [L_W-1:0]   L_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
`ifdef NETBIST_ONES_CNT_EN
    ,
    output logic [S_W+L_W:0] ones_cnt
`endif
);

    localparam int V_W   = S_W + L_W;
    // set_cnt only has to hold 0..SETTLE-1
    localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [V_W-1:0]   VEC_LAST = '1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

    bist_state_t      state_q;
    bist_state_t      state_d;
    logic [V_W-1:0]   vec_cnt;
    logic [SET_W-1:0] set_cnt;
    logic             settled;
    logic             last_vec;
    logic             sweep_go;
    logic             misr_shift;
    logic [SIG_W-1:0] misr_sig;
    logic [SIG_W-1:0] misr_nxt;

    assign settled  = (set_cnt == SET_LAST);
    assign last_vec = (vec_cnt == VEC_LAST);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_APPLY;
            ST_APPLY:  if (settled) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = last_vec ? ST_DONE : ST_APPLY;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from registered state and counters only
    always_comb begin
        logic active;
        active     = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
        busy       = active;
        done       = (state_q == ST_DONE);
        s_out      = active ? vec_cnt[S_W-1:0] : '0;
        L_out      = active ? vec_cnt[V_W-1:S_W] : '0;
        sweep_go   = (state_q == ST_IDLE) && start;
        misr_shift = (state_q == ST_SAMPLE);
    end

    // Vector and settle counters: cleared at start, stepped through the sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_cnt <= '0;
            set_cnt <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        vec_cnt <= '0;
                        set_cnt <= '0;
                    end
                end
                ST_APPLY: begin
                    if (!settled) set_cnt <= set_cnt + 1'b1;
                end
                ST_SAMPLE: begin
                    if (!last_vec) begin
                        vec_cnt <= vec_cnt + 1'b1;
                        set_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Verdict: graded on the final compaction so it is valid alongside done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else if (sweep_go) begin
            pass <= 1'b0;
        end else if (misr_shift && last_vec) begin
            pass <= (misr_nxt == expected_sig);
        end
    end

`ifdef NETBIST_ONES_CNT_EN
    // Count sampled ones over the sweep; holds after the sweep ends
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_cnt <= '0;
        end else if (sweep_go) begin
            ones_cnt <= '0;
        end else if (misr_shift && n_in) begin
            ones_cnt <= ones_cnt + 1'b1;
        end
    end
`endif

    netlist_bist_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (sweep_go),
        .shift   (misr_shift),
        .n_in    (n_in),
        .sig     (misr_sig),
        .sig_nxt (misr_nxt)
    );

    assign signature = misr_sig;

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// tb_netlist_bist_ctrl: bench for netlist_bist_ctrl. Instance A uses default
// parameters with n_in from a truth-table model of the netlist under test;
// instance B uses SEED=0, SETTLE=3 with n_in tied low.
module tb_netlist_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, start_b;
    logic [15:0] exp_a, exp_b;
    logic        n_a, n_b;
    logic [3:0]  a_s, b_s;
    logic [2:0]  a_l, b_l;
    logic        a_busy, a_done, a_pass, b_busy, b_done, b_pass;
    logic [15:0] a_sig, b_sig;
`ifdef NETBIST_ONES_CNT_EN
    logic [7:0]  a_ones, b_ones;
`endif

    // netlist-under-test model: truth table indexed by {L,s}, one flippable vector
    logic [127:0] tt;
    int           flip_vec;
    always_comb n_a = tt[{a_l, a_s}] ^ (flip_vec == int'({a_l, a_s}));
    assign n_b = 1'b0;

    netlist_bist_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected_sig(exp_a), .n_in(n_a),
        .s_out(a_s), .L_out(a_l), .busy(a_busy), .done(a_done), .pass(a_pass),
        .signature(a_sig)
`ifdef NETBIST_ONES_CNT_EN
        , .ones_cnt(a_ones)
`endif
    );

    netlist_bist_ctrl #(.SEED(16'h0000), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected_sig(exp_b), .n_in(n_b),
        .s_out(b_s), .L_out(b_l), .busy(b_busy), .done(b_done), .pass(b_pass),
        .signature(b_sig)
`ifdef NETBIST_ONES_CNT_EN
        , .ones_cnt(b_ones)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference signature: responses for vectors 0..127 in order, compacted
    // with the polynomial rule starting from seed.
    function automatic logic [15:0] ref_sig(input logic [15:0] seed, input logic [127:0] t,
                                            input int flip);
        logic [15:0] s;
        s = seed;
        for (int v = 0; v < 128; v++) begin
            logic r;
            r = t[v[6:0]] ^ (v == flip);
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, r};
        end
        return s;
    endfunction

    function automatic logic [6:0] vec_of(input int w);
        return (w == 0) ? {a_l, a_s} : {b_l, b_s};
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 0) ? a_busy : b_busy;
    endfunction
    function automatic logic done_of(input int w);
        return (w == 0) ? a_done : b_done;
    endfunction
    function automatic logic pass_of(input int w);
        return (w == 0) ? a_pass : b_pass;
    endfunction
    function automatic logic [15:0] sig_of(input int w);
        return (w == 0) ? a_sig : b_sig;
    endfunction

    // Run one sweep on instance w: checks vector order/hold time, done
    // latency, the one-cycle done pulse and that results hold afterwards.
    task automatic sweep(input int w, input int settle, output logic [15:0] sig, output logic pss);
        int per, total, bad, lat;
        per = settle + 1;
        total = 128 * per;
        bad = 0;
        lat = -1;
        sig = '0;
        pss = 1'b0;
        @(negedge clk);
        if (w == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int m = 0; m < total + 8; m++) begin
            @(negedge clk);
            if (done_of(w)) begin
                lat = m;
                sig = sig_of(w);
                pss = pass_of(w);
                if (busy_of(w) || vec_of(w) != 7'd0) bad++;
                break;
            end
            if (m >= total || !busy_of(w) || vec_of(w) != 7'(m / per)) bad++;
        end
        check($sformatf("dut%0d_vec_seq", w), bad, 0);
        check($sformatf("dut%0d_done_lat", w), lat, total);
        @(negedge clk);
        check($sformatf("dut%0d_done_pulse", w), {31'b0, done_of(w)}, 0);
        check($sformatf("dut%0d_hold", w), {15'b0, pass_of(w), sig_of(w)}, {15'b0, pss, sig});
    endtask

    typedef struct {
        int           flip;
        logic [127:0] tt;
        logic         exp_pass;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] sig;
        logic        pss;
        int          bad;
        int          found;
        logic        exp_p;

        tbl[0] = '{-1,  128'h0, 1'b1};
        tbl[1] = '{37,  128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0};
        tbl[2] = '{-1,  128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF, 1'b1};
        tbl[3] = '{0,   128'hF0F0F0F0F0F0F0F0_F0F0F0F0F0F0F0F0, 1'b0};
        tbl[4] = '{127, 128'h5555555555555555_5555555555555555, 1'b0};
        tbl[5] = '{-1,  128'hDEADBEEFCAFEF00D_0BADC0DE12345678, 1'b1};

        // clock/reset
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        exp_a = '0; exp_b = '0; tt = '0; flip_vec = -1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_s", {28'b0, a_s}, 0);
        check("rst_L", {29'b0, a_l}, 0);
        check("rst_busy", {31'b0, a_busy}, 0);
        check("rst_done", {31'b0, a_done}, 0);
        check("rst_pass", {31'b0, a_pass}, 0);
        check("rst_sig", {16'b0, a_sig}, 0);
        check("rst_b", {b_s, b_l, b_busy, b_done, b_pass, b_sig}, 0);

        // idle with start low: nothing moves
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if ({a_s, a_l, a_busy, a_done, a_pass, a_sig} != '0) bad++;
        end
        check("idle_quiet", bad, 0);

        // table-driven sweeps: golden signature from the fault-free model
        for (int i = 0; i < 6; i++) begin
            tt = tbl[i].tt;
            flip_vec = tbl[i].flip;
            exp_a = ref_sig(16'hFFFF, tt, -1);
            sweep(0, 1, sig, pss);
            check($sformatf("tbl%0d_pass", i), {31'b0, pss}, {31'b0, tbl[i].exp_pass});
            check($sformatf("tbl%0d_sig", i), {16'b0, sig}, {16'b0, ref_sig(16'hFFFF, tt, tbl[i].flip)});
        end

        // randomized netlists, optionally with one faulty vector
        for (int i = 0; i < 5; i++) begin
            tt = {$urandom(), $urandom(), $urandom(), $urandom()};
            flip_vec = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 127)) : -1;
            exp_a = ref_sig(16'hFFFF, tt, -1);
            exp_p = (ref_sig(16'hFFFF, tt, flip_vec) == exp_a);
            sweep(0, 1, sig, pss);
            check($sformatf("rnd%0d_pass", i), {31'b0, pss}, {31'b0, exp_p});
            check($sformatf("rnd%0d_sig", i), {16'b0, sig}, {16'b0, ref_sig(16'hFFFF, tt, flip_vec)});
        end

        // SEED=0, n_in=0, SETTLE=3: zero signature, 4-cycle vectors
        exp_b = '0;
        sweep(1, 3, sig, pss);
        check("b_sig", {16'b0, sig}, 0);
        check("b_pass", {31'b0, pss}, 1);

        // reset during vector 60 aborts the sweep
        tt = {$urandom(), $urandom(), $urandom(), $urandom()};
        flip_vec = -1;
        exp_a = ref_sig(16'hFFFF, tt, -1);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        found = 0;
        for (int m = 0; m < 300; m++) begin
            @(negedge clk);
            if (a_busy && {a_l, a_s} == 7'd60) begin
                found = 1;
                break;
            end
        end
        check("reach_v60", found, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_outputs", {7'b0, a_s, a_l, a_busy, a_done, a_pass, a_sig}, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_done || a_busy) bad++;
        end
        check("abort_no_done", bad, 0);
        sweep(0, 1, sig, pss);
        check("restart_sig", {16'b0, sig}, {16'b0, exp_a});
        check("restart_pass", {31'b0, pss}, 1);

`ifdef NETBIST_ONES_CNT_EN
        // n_in = L_out[2], start held: back-to-back sweeps each counting 64
        tt = {{64{1'b1}}, {64{1'b0}}};
        flip_vec = -1;
        @(negedge clk);
        start_a = 1'b1;
        for (int r = 0; r < 2; r++) begin
            found = 0;
            for (int m = 0; m < 600; m++) begin
                @(negedge clk);
                if (a_done) begin
                    found = 1;
                    break;
                end
            end
            check($sformatf("ones_done%0d", r), found, 1);
            check($sformatf("ones_cnt%0d", r), {24'b0, a_ones}, 64);
            if (r == 0) begin
                found = 0;
                for (int m = 0; m < 10; m++) begin
                    @(negedge clk);
                    if (a_busy) begin
                        found = 1;
                        break;
                    end
                end
                check("ones_restart", found, 1);
                check("ones_cleared", {24'b0, a_ones}, 0);
            end
        end
        start_a = 1'b0;
        repeat (4) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/netlist_bist_ctrl.md
# netlist_bist_ctrl

Built-in self-test sequencer for the small combinational standard-cell test netlists: 4-bit `s` bus and 3-bit `L` bus in, 1-bit `n` out. Sweeps every input combination exhaustively and holds each vector for a programmable settle time. Compacts the sampled `n` responses into a MISR signature and flags pass/fail against an expected signature. Sits beside the netlist under test; its vector outputs drive the netlist inputs and `n` feeds back.

## Interface
- `S_W`, 4, width of `s` vector
- `L_W`, 3, width of `L` vector
- `SIG_W`, 16, MISR signature width
- `POLY`, 16'h1021, MISR feedback polynomial (width `SIG_W`)
- `SEED`, 16'hFFFF, MISR value loaded at each start
- `SETTLE`, 1, cycles each vector is held before sampling (≥1)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  level-sampled start request
- `expected_sig`  in  SIG_W  golden signature; must be stable while `busy`
- `n_in`  in  1  response from the netlist under test
- `s_out`  out  S_W  drives netlist `s`
- `L_out`  out  L_W  drives netlist `L`
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at sweep end
- `pass`  out  1  signature matched; valid from `done`, held until next start
- `signature`  out  SIG_W  final MISR value, held until next start

## Operation
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE: with `start`=1, load MISR←`SEED`, `vec_cnt`←0, `set_cnt`←0, clear `pass` → APPLY.
- APPLY: `s_out`=`vec_cnt[S_W-1:0]`, `L_out`=`vec_cnt[S_W+L_W-1:S_W]`. Increment `set_cnt`; after `SETTLE` cycles → SAMPLE.
- SAMPLE: same vector still driven. At the clock edge ending this cycle, MISR ← (sig<<1) ^ ({SIG_W{sig[SIG_W-1]}} & POLY) ^ {0…,`n_in`}.
  - If `vec_cnt` = 2^(S_W+L_W)−1 → DONE.
  - Else `vec_cnt`+1, `set_cnt`←0 → APPLY.
- DONE: `done`=1 for exactly one cycle. `pass` is registered as (MISR == `expected_sig`), using the updated MISR. Then → IDLE.
- `start` is ignored outside IDLE. If `start` is still high in IDLE after DONE, a new sweep begins.
- `vec_cnt` is S_W+L_W bits and never wraps mid-sweep; the terminal compare ends the sweep.
- `s_out`/`L_out` are 0 in IDLE and DONE.
- `busy` = state ∈ {APPLY, SAMPLE}.

## Timing
- Reset (`rst_n`=0 at an edge) forces IDLE. Reset values:
  - `s_out`=0, `L_out`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0, counters 0.
  - This applies mid-sweep too: the sweep is aborted with no `done` pulse.
- Start at edge E0 (`start`=1 in IDLE): `busy`=1 and vector 0 is driven after E0.
- Each vector occupies SETTLE+1 cycles. `done` is high in the cycle after edge E0 + 2^(S_W+L_W)·(SETTLE+1).
  - Defaults: 128 vectors × 2 cycles, so `done` follows edge E0+256.
- `n_in` is sampled only at the final edge of SAMPLE and must be settled by then.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `NETBIST_ONES_CNT_EN` defined:
  - Adds output `ones_cnt` [S_W+L_W:0], the count of sampled `n_in`=1 over the sweep.
  - Cleared at start and held after DONE. Reset value 0.
  - Full sweep with `n_in`=1 gives 128.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `netlist_bist_pkg`:
  - FSM state enum.
  - Default `POLY`/`SEED` constants.
  - MISR next-state function.
- One sub-module `netlist_bist_misr` holds the signature register, with load/shift enables and the `n_in` input.
- Top level holds the FSM, the vector counter and the settle counter.

## Test plan
- Reset, then hold `rst_n`=1 with `start`=0 → all outputs 0 indefinitely; `busy` never rises.
- Defaults, `SEED`=0, `n_in` tied 0, `expected_sig`=0, pulse `start` → vectors 0…127 each driven 2 cycles; `done` follows edge E0+256; `signature`=0; `pass`=1.
- Defaults, `n_in` driven by a bench model of the netlist under test, `expected_sig` = bench MISR model → `pass`=1. Flip `n_in` for vector 37 only → `pass`=0 and the signature differs.
- `SETTLE`=3 → each vector held 4 cycles; `done` follows edge E0+512; `s_out`/`L_out` change only on 4-cycle boundaries.
- `rst_n` low at vector 60 → next cycle IDLE with all outputs 0 and no `done`. A following `start` restarts from vector 0 with `SEED`.
- `NETBIST_ONES_CNT_EN`, `n_in` = `L_out[2]` → `ones_cnt`=64 at `done`. `start` held high → back-to-back sweeps, and `ones_cnt` restarts at 0 each time.
